// File: rtl/vga_scan_pipe.sv
// vga_scan_pipe: 640x480@60 scan generator with a ROM-latency-matched pixel pipeline.
// Counters drive a combinational fetch stage (ROM address + sync decode). The fetch
// flags travel down an RD_LAT-deep delay line so that they meet rom_data at the
// output registers. All state advances only on ce.
module vga_scan_pipe #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic [18:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        HS,
  output logic        VS,
  output logic        blank,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
    logic first;
  } flags_t;

  localparam flags_t IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  logic [9:0] hc;
  logic [9:0] vc;
  flags_t     fetch;
  flags_t     dly_out;

  // Raster counters: column wraps into the next row, last row wraps to the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Fetch stage: ROM address and sync/active decode straight from the counters.
  always_comb begin
    fetch.act   = (hc < H_VIS) && (vc < V_VIS);
    fetch.hs_n  = !((hc >= HS_BEG) && (hc < HS_END));
    fetch.vs_n  = !((vc >= VS_BEG) && (vc < VS_END));
    fetch.first = (hc == '0) && (vc == '0);
    h_addr      = '0;
    v_addr      = '0;
    rom_addr    = '0;
    if (fetch.act) begin
      h_addr   = hc;
      v_addr   = vc;
      rom_addr = {hc, vc[8:0]};
    end
  end

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign dly_out = fetch;
    end else begin : g_lat
      flags_t stage [RD_LAT];

      // Delay line matching the ROM read latency so flags meet their pixel data.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < RD_LAT; i++) stage[i] <= IDLE;
        end else if (ce) begin
          stage[0] <= fetch;
          for (int unsigned i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign dly_out = stage[RD_LAT-1];
    end
  endgenerate

  // Output registers: sync, blank and colour sampled together; colour gated by blank.
  // frame_start is cleared on any non-ce clock so it lasts exactly one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HS          <= 1'b1;
      VS          <= 1'b1;
      blank       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (ce) begin
      HS          <= dly_out.hs_n;
      VS          <= dly_out.vs_n;
      blank       <= dly_out.act;
      red         <= dly_out.act ? {rom_data[11:8], rom_data[11:8]} : '0;
      green       <= dly_out.act ? {rom_data[7:4],  rom_data[7:4]}  : '0;
      blue        <= dly_out.act ? {rom_data[3:0],  rom_data[3:0]}  : '0;
      frame_start <= dly_out.first;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scan_pipe.sv
// Bench for vga_scan_pipe: three reduced-geometry instances (RD_LAT 0, 1, 3) and one
// full 640x480 instance share clk/ce/reset. The reference derives every expected
// output from the number of enabled cycles since reset using plain raster arithmetic.
module tb_vga_scan_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;

  always #5 clk = ~clk;

  logic [18:0] ra [4];
  logic [9:0]  ha [4];
  logic [9:0]  va [4];
  logic        hs [4];
  logic        vs [4];
  logic        bl [4];
  logic        fs [4];
  logic [7:0]  rr [4];
  logic [7:0]  gg [4];
  logic [7:0]  bb [4];

  logic [11:0] rd0, rd1, rd3, rdb, p3a, p3b;

  // Reference geometry per instance.
  int h_act [4] = '{16, 16, 16, 640};
  int h_fp  [4] = '{2, 2, 2, 16};
  int h_syn [4] = '{3, 3, 3, 96};
  int h_bp  [4] = '{4, 4, 4, 48};
  int v_act [4] = '{6, 6, 6, 480};
  int v_fp  [4] = '{1, 1, 1, 10};
  int v_syn [4] = '{2, 2, 2, 2};
  int v_bp  [4] = '{2, 2, 2, 33};
  int lat   [4] = '{0, 1, 3, 1};

  vga_scan_pipe #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RD_LAT(0)) u_l0 (
    .clk(clk), .reset(reset), .ce(ce), .rom_addr(ra[0]), .rom_data(rd0),
    .h_addr(ha[0]), .v_addr(va[0]), .HS(hs[0]), .VS(vs[0]), .blank(bl[0]),
    .red(rr[0]), .green(gg[0]), .blue(bb[0]), .frame_start(fs[0]));

  vga_scan_pipe #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RD_LAT(1)) u_l1 (
    .clk(clk), .reset(reset), .ce(ce), .rom_addr(ra[1]), .rom_data(rd1),
    .h_addr(ha[1]), .v_addr(va[1]), .HS(hs[1]), .VS(vs[1]), .blank(bl[1]),
    .red(rr[1]), .green(gg[1]), .blue(bb[1]), .frame_start(fs[1]));

  vga_scan_pipe #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                  .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .RD_LAT(3)) u_l3 (
    .clk(clk), .reset(reset), .ce(ce), .rom_addr(ra[2]), .rom_data(rd3),
    .h_addr(ha[2]), .v_addr(va[2]), .HS(hs[2]), .VS(vs[2]), .blank(bl[2]),
    .red(rr[2]), .green(gg[2]), .blue(bb[2]), .frame_start(fs[2]));

  vga_scan_pipe #(.RD_LAT(1)) u_full (
    .clk(clk), .reset(reset), .ce(ce), .rom_addr(ra[3]), .rom_data(rdb),
    .h_addr(ha[3]), .v_addr(va[3]), .HS(hs[3]), .VS(vs[3]), .blank(bl[3]),
    .red(rr[3]), .green(gg[3]), .blue(bb[3]), .frame_start(fs[3]));

  // ROM models: contents = address[11:0], read latency counted in enabled cycles.
  assign rd0 = ra[0][11:0];
  always @(posedge clk) begin
    if (ce) begin
      rd1 <= ra[1][11:0];
      p3a <= ra[2][11:0];
      p3b <= p3a;
      rd3 <= p3b;
      rdb <= ra[3][11:0];
    end
  end

  // Reference time base: enabled cycles since reset, and whether the last clk was enabled.
  longint e;
  logic   last_en;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e       <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= ce;
      if (ce) e <= e + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h expected %0h at e=%0d", tag, got, want, e);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int ht, vt, fh, fv, oh, ov;
      longint fr, p, q;
      bit fact, oact, ohs, ovs, ofs;
      logic [11:0] d;
      logic [7:0] er, eg, eb;
      ht = h_act[i] + h_fp[i] + h_syn[i] + h_bp[i];
      vt = v_act[i] + v_fp[i] + v_syn[i] + v_bp[i];
      fr = longint'(ht) * vt;
      fh = 0; fv = 0; oh = 0; ov = 0;
      fact = 0; oact = 0; ohs = 1; ovs = 1; ofs = 0;
      if (!reset) begin
        p = e % fr;
        fh = int'(p % ht);
        fv = int'(p / ht);
        fact = (fh < h_act[i]) && (fv < v_act[i]);
        if (e >= lat[i] + 1) begin
          q = (e - lat[i] - 1) % fr;
          oh = int'(q % ht);
          ov = int'(q / ht);
          oact = (oh < h_act[i]) && (ov < v_act[i]);
          ohs = !((oh >= h_act[i] + h_fp[i]) && (oh < h_act[i] + h_fp[i] + h_syn[i]));
          ovs = !((ov >= v_act[i] + v_fp[i]) && (ov < v_act[i] + v_fp[i] + v_syn[i]));
          ofs = last_en && (q == 0);
        end
      end
      d  = 12'(((oh % 8) * 512) + (ov % 512));
      er = oact ? {d[11:8], d[11:8]} : 8'd0;
      eg = oact ? {d[7:4], d[7:4]} : 8'd0;
      eb = oact ? {d[3:0], d[3:0]} : 8'd0;
      check($sformatf("rom_addr%0d", i), 32'(ra[i]), fact ? 32'(fh * 512 + fv) : 32'd0);
      check($sformatf("h_addr%0d", i), 32'(ha[i]), fact ? 32'(fh) : 32'd0);
      check($sformatf("v_addr%0d", i), 32'(va[i]), fact ? 32'(fv) : 32'd0);
      check($sformatf("HS%0d", i), 32'(hs[i]), 32'(ohs));
      check($sformatf("VS%0d", i), 32'(vs[i]), 32'(ovs));
      check($sformatf("blank%0d", i), 32'(bl[i]), 32'(oact));
      check($sformatf("red%0d", i), 32'(rr[i]), 32'(er));
      check($sformatf("green%0d", i), 32'(gg[i]), 32'(eg));
      check($sformatf("blue%0d", i), 32'(bb[i]), 32'(eb));
      check($sformatf("frame_start%0d", i), 32'(fs[i]), 32'(ofs));
    end
  endtask

  task automatic step(input logic ce_v, input logic rst_v);
    @(negedge clk);
    ce    = ce_v;
    reset = rst_v;
    #1;
    check_all();
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1);
    // Full-size instance reaches column 300 of line 0, then reset lands mid-line.
    repeat (300) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1);
    // Continuous pixel clock: several small frames and a few full-size lines incl. HS.
    repeat (2000) step(1'b1, 1'b0);
    // Pixel strobe on every second clk.
    for (int k = 0; k < 1200; k++) step(1'((k % 2) == 0), 1'b0);
    // Random strobe with occasional reset pulses.
    repeat (2000) step(1'(($urandom % 4) != 0), 1'(($urandom % 500) == 0));
    repeat (600) step(1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
